// File: rtl/drac_pkg.sv
// Shared constants and types for the SIMD completion-side writeback tracker.
package drac_pkg;

    // Width of the scheduler's exe-stages field.
    localparam int SIMD_EXE_STAGES_W   = 6;
    // Longest granted latency. A non-reused DIV/REM takes this many cycles.
    localparam int SIMD_MAX_LAT        = 32;
    // Timing-wheel size. It must be a power of two and larger than SIMD_MAX_LAT.
    localparam int SIMD_WB_WHEEL_DEPTH = 64;
    // Width of the graduation-list tag.
    localparam int SIMD_WB_TAG_W       = 7;

    // One timing-wheel slot.
    typedef struct packed {
        logic                     valid;
        logic [SIMD_WB_TAG_W-1:0] tag;
        logic                     is_div;
    } simd_wb_slot_t;

endpackage

// File: rtl/simd_wb_slot_ram.sv
// Timing-wheel slot storage.
// Ports: one write port, one combinational read port whose slot is cleared
// every cycle, a probe of a slot's valid bit, and a clear of every slot.
module simd_wb_slot_ram
    import drac_pkg::*;
#(
    parameter int DEPTH  = SIMD_WB_WHEEL_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_all_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  simd_wb_slot_t     wr_slot_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output simd_wb_slot_t     rd_slot_o,
    input  logic [ADDR_W-1:0] probe_addr_i,
    output logic              probe_valid_o
);

    simd_wb_slot_t slots_q [DEPTH];

    assign rd_slot_o     = slots_q[rd_addr_i];
    assign probe_valid_o = slots_q[probe_addr_i].valid;

    // Reset and flush empty the whole wheel.
    // Otherwise, retire the slot being read and store the new entry.
    // The write address never equals the read address.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_all_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            slots_q[rd_addr_i] <= '0;
            if (wr_en_i) begin
                slots_q[wr_addr_i] <= wr_slot_i;
            end
        end
    end

endmodule

// File: rtl/simd_wb_tracker.sv
// SIMD writeback tracker.
// Each accepted issue is replayed as one writeback strobe exactly N cycles
// later, using a timing wheel. Slot collisions and illegal latencies raise
// sticky debug flags.
module simd_wb_tracker
    import drac_pkg::*;
#(
    parameter int TAG_W       = SIMD_WB_TAG_W,
    parameter int MAX_LAT     = SIMD_MAX_LAT,
    parameter int WHEEL_DEPTH = SIMD_WB_WHEEL_DEPTH
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         issue_valid_i,
    input  logic [SIMD_EXE_STAGES_W-1:0] issue_stages_i,
    input  logic [TAG_W-1:0]             issue_tag_i,
    input  logic                         issue_is_div_i,
    output logic                         wb_valid_o,
    output logic [TAG_W-1:0]             wb_tag_o,
    output logic                         wb_is_div_o,
    output logic [6:0]                   inflight_o,
    output logic                         div_inflight_o,
    output logic                         collision_o,
    output logic                         bad_latency_o
);

    localparam int PTR_W = $clog2(WHEEL_DEPTH);
    localparam logic [SIMD_EXE_STAGES_W-1:0] MaxLatStages = SIMD_EXE_STAGES_W'(MAX_LAT);

    logic [PTR_W-1:0] readPtr_q, readPtr_d;
    logic [PTR_W-1:0] targetAddr;
    logic [6:0]       inflightCnt_q, inflightCnt_d;
    logic [6:0]       divCnt_q, divCnt_d;
    logic             collision_q, collision_d;
    logic             badLatency_q, badLatency_d;

    simd_wb_slot_t    readSlot;
    simd_wb_slot_t    writeSlot;
    logic             targetValid;
    logic             latencyOk;
    logic             issueLive;
    logic             acceptIssue;
    logic             wbFire;

    // Flush discards any issue that arrives in the same cycle.
    assign issueLive   = issue_valid_i & ~flush_i;
    assign latencyOk   = (issue_stages_i != '0) && (issue_stages_i <= MaxLatStages);
    assign targetAddr  = readPtr_q + PTR_W'(issue_stages_i);
    assign acceptIssue = issueLive & latencyOk & ~targetValid;
    assign wbFire      = readSlot.valid & ~flush_i;

    assign writeSlot.valid  = 1'b1;
    assign writeSlot.tag    = issue_tag_i;
    assign writeSlot.is_div = issue_is_div_i;

    simd_wb_slot_ram #(
        .DEPTH  (WHEEL_DEPTH),
        .ADDR_W (PTR_W)
    ) slotRam (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_all_i   (flush_i),
        .wr_en_i       (acceptIssue),
        .wr_addr_i     (targetAddr),
        .wr_slot_i     (writeSlot),
        .rd_addr_i     (readPtr_q),
        .rd_slot_o     (readSlot),
        .probe_addr_i  (targetAddr),
        .probe_valid_o (targetValid)
    );

    // Next-state logic.
    // The wheel advances every cycle, and a flush empties both counters.
    // The error flags are sticky until reset.
    always_comb begin
        readPtr_d     = readPtr_q + 1'b1;
        inflightCnt_d = inflightCnt_q;
        divCnt_d      = divCnt_q;
        collision_d   = collision_q | (issueLive & latencyOk & targetValid);
        badLatency_d  = badLatency_q | (issueLive & ~latencyOk);
        if (flush_i) begin
            inflightCnt_d = '0;
            divCnt_d      = '0;
        end else begin
            case ({acceptIssue, wbFire})
                2'b10:   inflightCnt_d = inflightCnt_q + 7'd1;
                2'b01:   inflightCnt_d = inflightCnt_q - 7'd1;
                default: inflightCnt_d = inflightCnt_q;
            endcase
            case ({acceptIssue & issue_is_div_i, wbFire & readSlot.is_div})
                2'b10:   divCnt_d = divCnt_q + 7'd1;
                2'b01:   divCnt_d = divCnt_q - 7'd1;
                default: divCnt_d = divCnt_q;
            endcase
        end
    end

    // State registers. Synchronous reset clears everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            readPtr_q     <= '0;
            inflightCnt_q <= '0;
            divCnt_q      <= '0;
            collision_q   <= 1'b0;
            badLatency_q  <= 1'b0;
        end else begin
            readPtr_q     <= readPtr_d;
            inflightCnt_q <= inflightCnt_d;
            divCnt_q      <= divCnt_d;
            collision_q   <= collision_d;
            badLatency_q  <= badLatency_d;
        end
    end

    assign wb_valid_o     = wbFire;
    assign wb_tag_o       = readSlot.valid ? readSlot.tag : '0;
    assign wb_is_div_o    = readSlot.valid & readSlot.is_div;
    assign inflight_o     = inflightCnt_q;
    assign div_inflight_o = (divCnt_q != '0);
    assign collision_o    = collision_q;
    assign bad_latency_o  = badLatency_q;

endmodule

// File: tb/tb_simd_wb_tracker.sv
// Self-checking bench for simd_wb_tracker.
// The reference model keeps pending writebacks as (due cycle, tag, div)
// records and compares the DUT outputs against it in every cycle.
module tb_simd_wb_tracker;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       issue_valid_i = 1'b0;
    logic [5:0] issue_stages_i = '0;
    logic [6:0] issue_tag_i = '0;
    logic       issue_is_div_i = 1'b0;
    logic       wb_valid_o;
    logic [6:0] wb_tag_o;
    logic       wb_is_div_o;
    logic [6:0] inflight_o;
    logic       div_inflight_o;
    logic       collision_o;
    logic       bad_latency_o;

    typedef struct {
        int         due;
        logic [6:0] tag;
        logic       isDiv;
    } pend_t;

    pend_t pending[$];
    int    cyc = 0;
    bit    modelReady = 0;
    logic  colFlag = 1'b0;
    logic  badFlag = 1'b0;
    int    checks = 0;
    int    passes = 0;
    int    failures = 0;

    simd_wb_tracker dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .issue_valid_i  (issue_valid_i),
        .issue_stages_i (issue_stages_i),
        .issue_tag_i    (issue_tag_i),
        .issue_is_div_i (issue_is_div_i),
        .wb_valid_o     (wb_valid_o),
        .wb_tag_o       (wb_tag_o),
        .wb_is_div_o    (wb_is_div_o),
        .inflight_o     (inflight_o),
        .div_inflight_o (div_inflight_o),
        .collision_o    (collision_o),
        .bad_latency_o  (bad_latency_o)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk_i = ~clk_i;

    // Return the index of the pending entry due in cycle c, or -1 if none is.
    function automatic int findDue(input int c);
        for (int i = 0; i < pending.size(); i++) begin
            if (pending[i].due == c) return i;
        end
        return -1;
    endfunction

    // Compare one observed value with its expected value.
    task automatic checkOne(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
        end
    endtask

    // Compare every DUT output with the model for the current cycle.
    task automatic checkOutput();
        int   idx;
        logic divAny;
        idx    = findDue(cyc);
        divAny = 1'b0;
        foreach (pending[i]) if (pending[i].isDiv) divAny = 1'b1;
        checkOne("wb_valid", 32'(wb_valid_o), 32'((idx >= 0) && !flush_i));
        checkOne("wb_tag", 32'(wb_tag_o), (idx >= 0) ? 32'(pending[idx].tag) : 32'd0);
        checkOne("wb_is_div", 32'(wb_is_div_o), (idx >= 0) ? 32'(pending[idx].isDiv) : 32'd0);
        checkOne("inflight", 32'(inflight_o), 32'(pending.size()));
        checkOne("div_inflight", 32'(div_inflight_o), 32'(divAny));
        checkOne("collision", 32'(collision_o), 32'(colFlag));
        checkOne("bad_latency", 32'(bad_latency_o), 32'(badFlag));
    endtask

    // Advance the model by one clock edge, using the inputs of this cycle.
    task automatic modelUpdate();
        pend_t e;
        if (rst_i) begin
            pending.delete();
            colFlag = 1'b0;
            badFlag = 1'b0;
        end else if (flush_i) begin
            pending.delete();
        end else begin
            for (int i = pending.size() - 1; i >= 0; i--) begin
                if (pending[i].due == cyc) pending.delete(i);
            end
            if (issue_valid_i) begin
                if (issue_stages_i == 0 || int'(issue_stages_i) > 32) begin
                    badFlag = 1'b1;
                end else if (findDue(cyc + int'(issue_stages_i)) >= 0) begin
                    colFlag = 1'b1;
                end else begin
                    e.due   = cyc + int'(issue_stages_i);
                    e.tag   = issue_tag_i;
                    e.isDiv = issue_is_div_i;
                    pending.push_back(e);
                end
            end
        end
        cyc++;
    endtask

    // Drive one cycle: apply the inputs, check mid-cycle, then advance the model.
    task automatic applyStimulus(input logic v, input logic [5:0] n, input logic [6:0] tag,
                                 input logic div, input logic fl, input logic rs);
        issue_valid_i  = v;
        issue_stages_i = n;
        issue_tag_i    = tag;
        issue_is_div_i = div;
        flush_i        = fl;
        rst_i          = rs;
        @(negedge clk_i);
        if (modelReady) checkOutput();
        @(posedge clk_i);
        modelUpdate();
        if (rs) modelReady = 1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic issue(input logic [5:0] n, input logic [6:0] tag, input logic div);
        applyStimulus(1'b1, n, tag, div, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 6'd0, 7'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Directed scenarios first, then a randomized run against the model.
    initial begin
        @(posedge clk_i);
        #1;
        doReset();
        doReset();
        idle(2);

        // Latency 1: write back in the next cycle.
        idle(8);
        issue(6'd1, 7'd5, 1'b0);
        idle(3);

        // Three issues that all target the same slot.
        doReset();
        issue(6'd3, 7'd1, 1'b0);
        issue(6'd2, 7'd2, 1'b0);
        issue(6'd1, 7'd3, 1'b0);
        idle(4);

        // Division at maximum latency, with the read pointer wrapping.
        doReset();
        idle(40);
        issue(6'd32, 7'd9, 1'b1);
        idle(35);

        // Flush with three entries in flight and an issue in the same cycle.
        issue(6'd5, 7'd20, 1'b0);
        issue(6'd6, 7'd21, 1'b1);
        issue(6'd7, 7'd22, 1'b0);
        applyStimulus(1'b1, 6'd2, 7'd23, 1'b0, 1'b1, 1'b0);
        idle(10);

        // Illegal latencies.
        issue(6'd0, 7'd30, 1'b0);
        issue(6'd33, 7'd31, 1'b0);
        issue(6'd63, 7'd32, 1'b1);
        idle(3);

        // Reset while entries are in flight.
        doReset();
        for (int i = 0; i < 5; i++) issue(6'(10 + i), 7'(40 + i), 1'(i % 2));
        doReset();
        idle(64);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 600; i++) begin
            logic [5:0] n;
            logic       rs;
            logic       fl;
            n  = ($urandom_range(0, 19) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(1, 32));
            rs = (i % 150 == 149);
            fl = ($urandom_range(0, 39) == 0);
            applyStimulus(1'($urandom_range(0, 1)), n, 7'($urandom), 1'($urandom_range(0, 3) == 0), fl, rs);
        end
        idle(40);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
